// File: rtl/uart_ascii_rx.sv
// 8N1 UART receiver holding the last NUM_CHARS ASCII bytes for the display encoders.
// Optional hex-digit filter/upper-casing enabled by defining ASCII_FILTER_EN.
module uart_ascii_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int NUM_CHARS    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_serial,
    output logic [8*NUM_CHARS-1:0] char_out,
    output logic                   char_valid,
    output logic                   frame_err,
    output logic                   busy
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_idx;
    logic [7:0]             r_byte;
    logic [8*NUM_CHARS-1:0] r_chars;
    logic                   r_char_valid;
    logic                   r_frame_err;
    logic                   w_tick_half;
    logic                   w_tick_full;
    logic                   w_shift_bit;
    logic                   w_commit;
    logic                   w_ferr;
    logic                   w_busy;
    logic                   w_byte_ok;
    logic [7:0]             w_byte_out;

    assign w_tick_half = (r_cnt == HALF_LAST);
    assign w_tick_full = (r_cnt == FULL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!r_rx_s) w_next = S_START;
            S_START: if (w_tick_half) w_next = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick_full && r_idx == 3'd7) w_next = S_STOP;
            S_STOP:  if (w_tick_full) w_next = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (r_rx_s) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != S_IDLE);
        w_shift_bit = 1'b0;
        w_commit    = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_DATA: w_shift_bit = w_tick_full;
            S_STOP: begin
                if (w_tick_full) begin
                    if (r_rx_s) w_commit = w_byte_ok;
                    else        w_ferr   = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef ASCII_FILTER_EN
    always_comb begin
        w_byte_ok  = ((r_byte >= 8'h30) && (r_byte <= 8'h39)) ||
                     ((r_byte >= 8'h41) && (r_byte <= 8'h46)) ||
                     ((r_byte >= 8'h61) && (r_byte <= 8'h66));
        w_byte_out = r_byte;
        if ((r_byte >= 8'h61) && (r_byte <= 8'h66)) w_byte_out[5] = 1'b0;
    end
`else
    always_comb begin
        w_byte_ok  = 1'b1;
        w_byte_out = r_byte;
    end
`endif

    // Counters restart on every tick so a back-to-back start bit is seen from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            case (r_state)
                S_START: r_cnt <= w_tick_half ? '0 : r_cnt + CW'(1);
                S_DATA, S_STOP: r_cnt <= w_tick_full ? '0 : r_cnt + CW'(1);
                default: r_cnt <= '0;
            endcase
            if (r_state != S_DATA) r_idx <= '0;
            else if (w_tick_full)  r_idx <= r_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte       <= '0;
            r_chars      <= {NUM_CHARS{8'h20}};
            r_char_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_char_valid <= w_commit;
            r_frame_err  <= w_ferr;
            if (w_shift_bit) r_byte <= {r_rx_s, r_byte[7:1]};
            if (w_commit) begin
                for (int unsigned k = 1; k < NUM_CHARS; k++)
                    r_chars[8*k +: 8] <= r_chars[8*(k-1) +: 8];
                r_chars[7:0] <= w_byte_out;
            end
        end
    end

    assign char_out   = r_chars;
    assign char_valid = r_char_valid;
    assign frame_err  = r_frame_err;
    assign busy       = w_busy;
endmodule

// File: tb/tb_uart_ascii_rx.sv
// Scoreboard bench for uart_ascii_rx at CLKS_PER_BIT=8, NUM_CHARS=2.
// Expectations follow ASCII_FILTER_EN when it is defined for the build.
module tb_uart_ascii_rx;
    localparam int CPB = 8;
    localparam int NC  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_serial = 1'b1;
    logic [8*NC-1:0] char_out;
    logic          char_valid;
    logic          frame_err;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int n_valid = 0;
    int n_ferr = 0;
    logic [7:0]  sb[$];
    logic [15:0] exp_chars = 16'h2020;

    uart_ascii_rx #(.CLKS_PER_BIT(CPB), .NUM_CHARS(NC)) dut (
        .clk(clk), .reset(reset), .rx_serial(rx_serial),
        .char_out(char_out), .char_valid(char_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (char_valid && frame_err) begin
                checks++; failures++;
                $display("FAIL pulse_overlap: char_valid and frame_err both high");
            end
            if (char_valid) begin
                logic [7:0] e;
                n_valid++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid: got %h, none expected", char_out[7:0]);
                end else begin
                    e = sb.pop_front();
                    if (char_out[7:0] !== e) begin
                        failures++;
                        $display("FAIL slot0: got %h expected %h", char_out[7:0], e);
                    end
                end
            end
            if (frame_err) n_ferr++;
        end
    end

    function automatic bit model_ok(input logic [7:0] b);
`ifdef ASCII_FILTER_EN
        return (b inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]});
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] model_map(input logic [7:0] b);
`ifdef ASCII_FILTER_EN
        if (b inside {[8'h61:8'h66]}) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        rx_serial = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            cycles(CPB);
        end
        rx_serial = stop_bit;
        cycles(stop_len);
        rx_serial = 1'b1;
    endtask

    task automatic send_expect(input logic [7:0] b);
        if (model_ok(b)) begin
            sb.push_back(model_map(b));
            exp_chars = {exp_chars[7:0], model_map(b)};
        end
        send_frame(b, 1'b1, CPB);
    endtask

    task automatic test_reset;
        cycles(3);
        reset = 1'b0;
        cycles(100);
        checks++;
        if (char_out !== 16'h2020) begin failures++; $display("FAIL reset_chars: got %h expected 2020", char_out); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (n_valid != 0 || n_ferr != 0) begin failures++; $display("FAIL reset_pulses: valid=%0d ferr=%0d expected 0/0", n_valid, n_ferr); end
    endtask

    task automatic test_two_chars;
        int v0 = n_valid;
        send_expect(8'h31);
        cycles(2);
        checks++;
        if (char_out !== 16'h2031) begin failures++; $display("FAIL first_char: got %h expected 2031", char_out); end
        send_expect(8'h41);
        cycles(4);
        checks++;
        if (char_out !== 16'h3141) begin failures++; $display("FAIL two_chars: got %h expected 3141", char_out); end
        checks++;
        if (n_valid - v0 != 2) begin failures++; $display("FAIL two_chars_pulses: got %0d expected 2", n_valid - v0); end
    endtask

    task automatic test_glitch;
        int v0 = n_valid;
        int f0 = n_ferr;
        rx_serial = 1'b0;
        cycles(3);
        rx_serial = 1'b1;
        cycles(20);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        checks++;
        if (n_valid != v0 || n_ferr != f0) begin failures++; $display("FAIL glitch_pulses: valid+%0d ferr+%0d expected 0/0", n_valid - v0, n_ferr - f0); end
        checks++;
        if (char_out !== exp_chars) begin failures++; $display("FAIL glitch_chars: got %h expected %h", char_out, exp_chars); end
    endtask

    task automatic test_frame_error;
        int v0 = n_valid;
        int f0 = n_ferr;
        send_frame(8'h35, 1'b0, 40);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL break_busy: got %b expected 1", busy); end
        cycles(6);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL break_release: got %b expected 0", busy); end
        checks++;
        if (n_ferr - f0 != 1) begin failures++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
        checks++;
        if (n_valid != v0) begin failures++; $display("FAIL ferr_valid: got %0d expected 0", n_valid - v0); end
        checks++;
        if (char_out !== 16'h3141) begin failures++; $display("FAIL ferr_chars: got %h expected 3141", char_out); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b = 8'h39;
        rx_serial = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_serial = b[i];
            cycles(CPB);
        end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midframe_busy: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        checks++;
        if (char_out !== 16'h2020 || busy !== 1'b0 || char_valid !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: chars=%h busy=%b valid=%b ferr=%b expected 2020/0/0/0", char_out, busy, char_valid, frame_err);
        end
        rx_serial = 1'b1;
        exp_chars = 16'h2020;
        cycles(3);
        reset = 1'b0;
        cycles(10);
        send_expect(8'h32);
        cycles(4);
        checks++;
        if (char_out !== 16'h2032) begin failures++; $display("FAIL after_reset: got %h expected 2032", char_out); end
    endtask

    task automatic test_filter;
        int v0 = n_valid;
        int f0 = n_ferr;
        send_expect(8'h61);
        send_expect(8'h5A);
        cycles(4);
        checks++;
`ifdef ASCII_FILTER_EN
        if (char_out !== 16'h3241 || n_valid - v0 != 1) begin
            failures++; $display("FAIL filter: chars=%h pulses=%0d expected 3241/1", char_out, n_valid - v0);
        end
`else
        if (char_out !== 16'h615A || n_valid - v0 != 2) begin
            failures++; $display("FAIL filter: chars=%h pulses=%0d expected 615A/2", char_out, n_valid - v0);
        end
`endif
        checks++;
        if (n_ferr != f0) begin failures++; $display("FAIL filter_ferr: got %0d expected 0", n_ferr - f0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] list [8] = '{8'h2F, 8'h30, 8'h39, 8'h3A, 8'h46, 8'h47, 8'h66, 8'h67};
        int v0 = n_valid;
        int acc = 0;
        foreach (list[i]) begin
            if (model_ok(list[i])) acc++;
            send_expect(list[i]);
        end
        send_expect(8'h37);
        send_expect(8'h38);
        acc += 2;
        cycles(4);
        checks++;
        if (char_out !== 16'h3738) begin failures++; $display("FAIL b2b_chars: got %h expected 3738", char_out); end
        checks++;
        if (n_valid - v0 != acc) begin failures++; $display("FAIL b2b_pulses: got %0d expected %0d", n_valid - v0, acc); end
    endtask

    initial begin
        test_reset();
        test_two_chars();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        test_filter();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d left expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
